burst_addr_gen_param: RTL and testbench
=======================================

# burst_addr_gen_param

Parametrised burst address generator for the MRAM serial interface. It serially loads a start address and burst length, then emits one serial address per beat, MSB first, toward the STP/PTS datapath. It supports single, incrementing-burst and wrapping-burst modes, and paces beats with a downstream ready handshake. It sits between the host-side serial command inputs and the address mux in front of the STP/PTS module.

## Interface
- `ADDR_W`, default 8: address width in bits; also the serial load length and the per-beat shift-out length.
- `LEN_W`, default 4: burst-length field width. Must satisfy `LEN_W <= ADDR_W`. A field value of N means N+1 beats.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `burst_en` in 1: starts an operation from IDLE; deassertion aborts any operation in progress.
- `mode_sel` in 1: 0 = single transfer, 1 = burst.
- `wrap_sel` in 1: 0 = incrementing, 1 = wrapping (burst mode only).
- `burst_len_in` in 1: serial burst length, MSB first.
- `addr_in` in 1: serial start address, MSB first.
- `beat_ready` in 1: downstream ready for the next address beat.
- `addr_sel` out 1: mux select; 1 = use `addr_ser_out`.
- `addr_ser_out` out 1: serial generated address, MSB first.
- `addr_valid` out 1: high on every cycle a valid address bit is on `addr_ser_out`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse at normal burst completion.
- `beat_cnt` out LEN_W: index of the current or last emitted beat.

## Operation
- States: IDLE, LOAD, WAIT, SHIFT, NEXT, DONE.
- **IDLE → LOAD** when `burst_en`=1. On that transition, latch `mode_sel` and `wrap_sel`, and clear the counters.
- **LOAD** lasts exactly ADDR_W cycles.
  - `addr_in` is shifted in on each edge.
  - `burst_len_in` is shifted in only on the first LEN_W edges.
  - Then → WAIT.
- **Beat count:**
  - Single mode forces the beat count to 1, regardless of the loaded length.
  - Burst mode uses beats = len+1, giving 1..2^LEN_W.
- **WAIT** → SHIFT on an edge with `beat_ready`=1; otherwise hold. There is no timeout.
- **SHIFT** lasts exactly ADDR_W cycles.
  - `addr_sel`=1 and `addr_valid`=1.
  - `addr_ser_out` = current address MSB down to LSB.
  - After the last bit: → NEXT if beats remain, else → DONE.
- **NEXT** lasts one cycle.
  - Increment `beat_cnt` and compute the next address.
  - → WAIT.
- **DONE** lasts one cycle with `done`=1, then → IDLE.
- **Incrementing:** next = (addr + 1) mod 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
- **Wrapping:** only valid when beats is a power of two (1, 2, 4, …).
  - Low log2(beats) bits increment modulo beats; the upper bits are held.
  - If beats is not a power of two, behave as incrementing.
- **Abort:** `burst_en`=0 in any non-IDLE state → IDLE on the next edge.
  - All outputs return to reset values.
  - No `done` pulse.
  - The partial load is discarded.
- **Simultaneous events:** abort takes priority over `beat_ready` and over completion. `rst` takes priority over everything.
- `mode_sel` and `wrap_sel` changes outside IDLE are ignored.

## Timing
- Reset values: `addr_sel`=0, `addr_ser_out`=0, `addr_valid`=0, `busy`=0, `done`=0, `beat_cnt`=0; state IDLE.
- **Load timing:** `burst_en` sampled at edge k. Load bits are sampled at edges k+1 … k+ADDR_W. WAIT is entered at edge k+ADDR_W+1.
- **First beat:** with `beat_ready` held high, the first address MSB appears one cycle after WAIT is entered. Latency from `burst_en` sample to first address bit is ADDR_W+2 cycles.
- **Beat cadence:** ADDR_W (SHIFT) + 1 (NEXT) + 1 (WAIT) = ADDR_W+2 cycles per beat under continuous ready.
- **Outputs:** all outputs are registered. `addr_ser_out` is 0 outside SHIFT.
- **done:** asserted for exactly the cycle after the last SHIFT bit.

## Configuration
- Macro: `BURST_WRAP_EN`.
- **Defined:** wrapping mode is implemented as above.
- **Undefined:**
  - `wrap_sel` is ignored and not latched.
  - All bursts are incrementing.
  - The wrap-mask logic is absent.

## Test plan
- **Incrementing burst** (ADDR_W=8, LEN_W=4): `mode_sel`=1, `wrap_sel`=0, addr 0x10, len 3, `beat_ready`=1 → serial addresses 0x10, 0x11, 0x12, 0x13; `done` pulses once; `busy` falls the cycle after.
- **Wrapping burst** (`BURST_WRAP_EN` defined): addr 0x0E, len 3 → 0x0E, 0x0F, 0x0C, 0x0D. With the macro undefined → 0x0E, 0x0F, 0x10, 0x11.
- **Single mode:** `mode_sel`=0, addr 0xA5, len 5 → exactly one beat 0xA5, then `done`; `beat_cnt`=0.
- **Address rollover:** incrementing, addr 0xFF, len 1 → 0xFF, 0x00.
- **Backpressure:** `beat_ready`=0 for 7 cycles before beat 2 → FSM holds in WAIT with `addr_valid`=0; beat 2 starts one cycle after `beat_ready` rises and the address is unchanged.
- **Abort:** drop `burst_en` during the 3rd SHIFT bit of beat 1 → next cycle all outputs at reset values and no `done`. A new `burst_en` then loads a fresh address correctly.

Source files
------------

// File: rtl/burst_addr_gen_param.sv
// burst_addr_gen_param: serial-load burst address generator with ready-paced MSB-first beats; define BURST_WRAP_EN to enable wrapping bursts
module burst_addr_gen_param #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             burst_en,
  input  logic             mode_sel,
  input  logic             wrap_sel,
  input  logic             burst_len_in,
  input  logic             addr_in,
  input  logic             beat_ready,
  output logic             addr_sel,
  output logic             addr_ser_out,
  output logic             addr_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_cnt
);
  localparam int CW = $clog2(ADDR_W + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, NEXT, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr_q, sh_q, addr_inc, next_addr;
  logic [LEN_W-1:0]  len_q, last_idx;
  logic [CW-1:0]     cnt;
  logic              mode_q;
  assign addr_inc = addr_q + ADDR_W'(1);
  assign last_idx = mode_q ? len_q : '0;
`ifdef BURST_WRAP_EN
  logic              wrap_q;
  logic [ADDR_W-1:0] mask;
  assign mask = ADDR_W'(len_q);
  assign next_addr = (wrap_q && mode_q && (len_q & (len_q + LEN_W'(1))) == '0)
                     ? (addr_q & ~mask) | (addr_inc & mask) : addr_inc;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_sel;
  assign next_addr = addr_inc;
`endif
  // Control FSM: reset and abort share one path back to IDLE; every output is registered
  always_ff @(posedge clk) begin
    if (rst || (state != IDLE && !burst_en)) begin
      state        <= IDLE;
      addr_sel     <= 1'b0;
      addr_ser_out <= 1'b0;
      addr_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      beat_cnt     <= '0;
      cnt          <= '0;
      addr_q       <= '0;
      sh_q         <= '0;
      len_q        <= '0;
      mode_q       <= 1'b0;
`ifdef BURST_WRAP_EN
      wrap_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (burst_en) begin
          state    <= LOAD;
          busy     <= 1'b1;
          mode_q   <= mode_sel;
`ifdef BURST_WRAP_EN
          wrap_q   <= wrap_sel;
`endif
          cnt      <= '0;
          beat_cnt <= '0;
        end
        LOAD: if (cnt == CW'(ADDR_W)) begin
          state <= WAIT;
          cnt   <= '0;
        end else begin
          addr_q <= (addr_q << 1) | ADDR_W'(addr_in);
          len_q  <= (cnt < CW'(LEN_W)) ? (len_q << 1) | LEN_W'(burst_len_in) : len_q;
          cnt    <= cnt + CW'(1);
        end
        WAIT: if (beat_ready) begin
          state        <= SHIFT;
          addr_sel     <= 1'b1;
          addr_valid   <= 1'b1;
          addr_ser_out <= addr_q[ADDR_W-1];
          sh_q         <= addr_q << 1;
          cnt          <= CW'(1);
        end
        SHIFT: if (cnt == CW'(ADDR_W)) begin
          state        <= (beat_cnt == last_idx) ? DONE : NEXT;
          done         <= beat_cnt == last_idx;
          addr_sel     <= 1'b0;
          addr_valid   <= 1'b0;
          addr_ser_out <= 1'b0;
          cnt          <= '0;
        end else begin
          addr_ser_out <= sh_q[ADDR_W-1];
          sh_q         <= sh_q << 1;
          cnt          <= cnt + CW'(1);
        end
        NEXT: begin
          state    <= WAIT;
          beat_cnt <= beat_cnt + LEN_W'(1);
          addr_q   <= next_addr;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_addr_gen_param.sv
// tb_burst_addr_gen_param: directed table-driven bench for burst_addr_gen_param (ADDR_W=8, LEN_W=4)
module tb_burst_addr_gen_param;
  logic clk = 1'b0;
  logic rst, burst_en, mode_sel, wrap_sel, burst_len_in, addr_in, beat_ready;
  logic addr_sel, addr_ser_out, addr_valid, busy, done;
  logic [3:0] beat_cnt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  burst_addr_gen_param #(.ADDR_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .burst_en(burst_en), .mode_sel(mode_sel), .wrap_sel(wrap_sel),
    .burst_len_in(burst_len_in), .addr_in(addr_in), .beat_ready(beat_ready),
    .addr_sel(addr_sel), .addr_ser_out(addr_ser_out), .addr_valid(addr_valid),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  typedef struct {
    logic       m, w;
    logic [7:0] a;
    logic [3:0] l;
    bit         gap;
    int         n;
    logic [7:0] e [4];
    int         bc;
    int         f1;
  } vec_t;
  vec_t v [8];

  logic [7:0] got [16];
  int nb, nd, bc_at_done, busy_after, done_after;
  int first_v [16];
  bit ser_bad, sel_bad, timeout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_v(input int i, input logic m, input logic w, input logic [7:0] a,
                       input logic [3:0] l, input bit gap, input int n,
                       input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                       input logic [7:0] e3, input int bc, input int f1);
    v[i].m = m; v[i].w = w; v[i].a = a; v[i].l = l; v[i].gap = gap; v[i].n = n;
    v[i].e[0] = e0; v[i].e[1] = e1; v[i].e[2] = e2; v[i].e[3] = e3;
    v[i].bc = bc; v[i].f1 = f1;
  endtask

  // raises burst_en, then shifts address/length in; mode/wrap are flipped after latching
  task automatic start_load(input logic m, input logic w, input logic [7:0] a, input logic [3:0] l);
    @(negedge clk);
    burst_en = 1'b1; mode_sel = m; wrap_sel = w; beat_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      addr_in = a[7-i];
      burst_len_in = (i < 4) ? l[3-i] : 1'b1;
      mode_sel = ~m;
      wrap_sel = ~w;
    end
  endtask

  // watches beats until the cycle after done; cyc 0 is the last LOAD cycle
  task automatic collect(input bit gap);
    int bits = 0, low_left = 0;
    logic [7:0] cur = 8'h0;
    bit done_prev = 1'b0;
    nb = 0; nd = 0; bc_at_done = -1; busy_after = -1; done_after = -1;
    ser_bad = 1'b0; sel_bad = 1'b0; timeout = 1'b1;
    for (int i = 0; i < 16; i++) first_v[i] = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (done_prev) begin
        busy_after = int'(busy);
        done_after = int'(done);
        timeout = 1'b0;
        break;
      end
      if (low_left > 0) begin
        low_left--;
        if (low_left == 0) beat_ready = 1'b1;
      end
      if (addr_sel !== addr_valid) sel_bad = 1'b1;
      if (!addr_valid && addr_ser_out !== 1'b0) ser_bad = 1'b1;
      if (addr_valid) begin
        if (bits == 0) first_v[nb] = cyc;
        cur = {cur[6:0], addr_ser_out};
        bits++;
        if (bits == 8) begin
          got[nb] = cur;
          nb++;
          bits = 0;
          if (gap && nb == 1) begin
            beat_ready = 1'b0;
            low_left = 7;
          end
        end
      end
      if (done) begin
        nd++;
        bc_at_done = int'(beat_cnt);
      end
      done_prev = done;
    end
    burst_en = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t t);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_beats"}, nb, t.n);
    for (int b = 0; b < t.n && b < 4; b++) chk($sformatf("%s_addr%0d", tag, b), 32'(got[b]), 32'(t.e[b]));
    chk({tag, "_done_pulses"}, nd, 1);
    chk({tag, "_beat_cnt"}, bc_at_done, t.bc);
    chk({tag, "_first_beat_cyc"}, first_v[0], 2);
    if (t.f1 >= 0) chk({tag, "_second_beat_cyc"}, first_v[1], t.f1);
    chk({tag, "_busy_after"}, busy_after, 0);
    chk({tag, "_done_after"}, done_after, 0);
    chk({tag, "_ser_idle_zero"}, 32'(ser_bad), 0);
    chk({tag, "_sel_eq_valid"}, 32'(sel_bad), 0);
  endtask

  initial begin
    int dcount;
    bit reached;
    rst = 1'b1; burst_en = 1'b1; mode_sel = 1'b0; wrap_sel = 1'b0;
    burst_len_in = 1'b0; addr_in = 1'b0; beat_ready = 1'b1;

    set_v(0, 1, 0, 8'h10, 4'd3,  0, 4, 8'h10, 8'h11, 8'h12, 8'h13, 3, 12);
`ifdef BURST_WRAP_EN
    set_v(1, 1, 1, 8'h0E, 4'd3,  0, 4, 8'h0E, 8'h0F, 8'h0C, 8'h0D, 3, 12);
    set_v(7, 1, 1, 8'h07, 4'd1,  0, 2, 8'h07, 8'h06, 8'h00, 8'h00, 1, 12);
`else
    set_v(1, 1, 1, 8'h0E, 4'd3,  0, 4, 8'h0E, 8'h0F, 8'h10, 8'h11, 3, 12);
    set_v(7, 1, 1, 8'h07, 4'd1,  0, 2, 8'h07, 8'h08, 8'h00, 8'h00, 1, 12);
`endif
    set_v(2, 0, 0, 8'hA5, 4'd5,  0, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 0, -1);
    set_v(3, 1, 0, 8'hFF, 4'd1,  0, 2, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 12);
    set_v(4, 1, 0, 8'h3C, 4'd2,  1, 3, 8'h3C, 8'h3D, 8'h3E, 8'h00, 2, 17);
    set_v(5, 1, 1, 8'h0E, 4'd2,  0, 3, 8'h0E, 8'h0F, 8'h10, 8'h00, 2, 12);
    set_v(6, 0, 1, 8'h5A, 4'd15, 0, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 0, -1);

    repeat (3) @(negedge clk);
    chk("rst_addr_sel", 32'(addr_sel), 0);
    chk("rst_addr_ser_out", 32'(addr_ser_out), 0);
    chk("rst_addr_valid", 32'(addr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_beat_cnt", 32'(beat_cnt), 0);
    rst = 1'b0; burst_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_load(v[i].m, v[i].w, v[i].a, v[i].l);
      collect(v[i].gap);
      check_result($sformatf("vec%0d", i), v[i]);
    end

    start_load(1'b1, 1'b0, 8'h40, 4'd3);
    reached = 1'b0;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (addr_valid) dcount++;
      if (dcount == 3) begin
        burst_en = 1'b0;
        reached = 1'b1;
        break;
      end
    end
    chk("abort_reached_bit3", 32'(reached), 1);
    @(negedge clk);
    chk("abort_addr_sel", 32'(addr_sel), 0);
    chk("abort_addr_ser_out", 32'(addr_ser_out), 0);
    chk("abort_addr_valid", 32'(addr_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_beat_cnt", 32'(beat_cnt), 0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("abort_quiet", dcount, 0);

    begin
      vec_t t;
      t.m = 1; t.w = 0; t.a = 8'h77; t.l = 4'd1; t.gap = 0; t.n = 2;
      t.e[0] = 8'h77; t.e[1] = 8'h78; t.e[2] = 8'h00; t.e[3] = 8'h00; t.bc = 1; t.f1 = 12;
      start_load(t.m, t.w, t.a, t.l);
      collect(t.gap);
      check_result("after_abort", t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
